// File: rtl/pistorm_pkg.sv
// Shared definitions for the Pi-side transaction front end: register codes,
// status bit positions, FSM state type and the bus command record.
package pistorm_pkg;

  localparam int unsigned PI_ADDR_W = 24;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Written STATUS bit that keeps the 68K out of reset; read-back bit positions follow.
  localparam int unsigned STAT_RUN       = 1;
  localparam int unsigned STAT_RESET_REQ = 1;
  localparam int unsigned STAT_BERR      = 2;
  localparam int unsigned STAT_OVERRUN   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fsm_t;

  typedef struct packed {
    logic [PI_ADDR_W-1:0] addr;
    logic                 rw;
    logic                 isByte;
    logic [2:0]           fc;
    logic [15:0]          wdata;
  } cmd_t;

  function automatic logic [15:0] statusWord(input logic [2:0] ipl,
                                             input logic       overrun,
                                             input logic       berr,
                                             input logic       resetReq);
    logic [15:0] w;
    w                 = '0;
    w[15:13]          = ipl;
    w[STAT_OVERRUN]   = overrun;
    w[STAT_BERR]      = berr;
    w[STAT_RESET_REQ] = resetReq;
    return w;
  endfunction

endpackage

// File: rtl/pi_strobe_sync.sv
// Synchroniser for an asynchronous Pi strobe with a single-cycle pulse on
// each rising edge seen after the synchroniser chain.
module pi_strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pi_txn_frontend.sv
// Pi register front end issuing one 68K bus command per ADDR_HI write.
// Optional build macro PI_POSTED_WRITE_EN: posted writes plus a 1-entry launch skid.
module pi_txn_frontend
  import pistorm_pkg::*;
#(
  parameter int unsigned ADDR_W      = PI_ADDR_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              pi_clk_i,
  input  logic              sys_reset_n_i,
  input  logic [1:0]        pi_a_i,
  input  logic              pi_rd_i,
  input  logic              pi_wr_i,
  input  logic [15:0]       pi_d_in_i,
  output logic [15:0]       pi_d_out_o,
  output logic              pi_d_oe_o,
  output logic              pi_txn_in_progress_o,
  input  logic [2:0]        ipl_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic              cmd_rw_o,
  output logic              cmd_byte_o,
  output logic [2:0]        cmd_fc_o,
  output logic [15:0]       cmd_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [15:0]       rsp_rdata_i,
  input  logic              rsp_berr_i,
  output logic              reset_req_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TIMEOUT_CYC);

  logic rdPulse, wrPulse;

  pi_strobe_sync #(.STAGES(SYNC_STAGES)) uRdSync (
    .clk_i    (pi_clk_i),
    .rst_ni   (sys_reset_n_i),
    .strobe_i (pi_rd_i),
    .pulse_o  (rdPulse)
  );

  pi_strobe_sync #(.STAGES(SYNC_STAGES)) uWrSync (
    .clk_i    (pi_clk_i),
    .rst_ni   (sys_reset_n_i),
    .strobe_i (pi_wr_i),
    .pulse_o  (wrPulse)
  );

  fsm_t        state_q, state_d;
  cmd_t        cmd_q, cmd_d, newCmd;
  logic        txn_q, txn_d;
  logic        run_q;
  logic        overrun_q, overrun_d;
  logic        berr_q, berr_d;
  logic [15:0] addrLo_q, wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] statusRd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic launchReq, abort, statusRdHit, handshake;
  logic rspRetire, timeoutRetire, retire;
  logic txnFree, launchOk, launchDirect;
  logic skidBusy;

`ifdef PI_POSTED_WRITE_EN
  cmd_t skid_q, skid_d;
  logic skidValid_q, skidValid_d;
  logic skidLoad;

  // A launch accepted while the engine is still busy with a posted write waits here.
  always_comb begin
    skid_d      = skid_q;
    skidValid_d = skidValid_q;
    skidLoad    = launchOk && !launchDirect;
    if (abort) begin
      skidValid_d = 1'b0;
    end else if (skidLoad) begin
      skidValid_d = 1'b1;
      skid_d      = newCmd;
    end else if (retire) begin
      skidValid_d = 1'b0;
    end
  end

  always_ff @(posedge pi_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      skid_q      <= '0;
      skidValid_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skidValid_q <= skidValid_d;
    end
  end

  assign skidBusy = skidValid_q;
`else
  assign skidBusy = 1'b0;
`endif

  always_comb begin
    newCmd        = '0;
    newCmd.addr   = PI_ADDR_W'({pi_d_in_i[ADDR_W-17:0], addrLo_q});
    newCmd.rw     = pi_d_in_i[9];
    newCmd.isByte = pi_d_in_i[8];
    newCmd.fc     = pi_d_in_i[15:13];
    newCmd.wdata  = wdata_q;
  end

  // Abort beats everything; a retiring response frees the slot for a same-cycle launch.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    txn_d         = txn_q;
    launchReq     = wrPulse && (pi_a_i == REG_ADDR_HI);
    abort         = wrPulse && (pi_a_i == REG_STATUS) && !pi_d_in_i[STAT_RUN];
    statusRdHit   = rdPulse && (pi_a_i == REG_STATUS);
    handshake     = (state_q == ISSUE) && cmd_ready_i && !abort;
    rspRetire     = (state_q == WAIT) && rsp_valid_i && !abort;
    timeoutRetire = (TIMEOUT_CYC != 0) && (state_q == WAIT) && !rsp_valid_i &&
                    (cnt_q == TO_LAST) && !abort;
    retire        = rspRetire || timeoutRetire;
    txnFree       = !txn_q || (retire && !skidBusy);
    launchOk      = launchReq && txnFree;
    launchDirect  = launchOk && ((state_q == IDLE) || retire);

    if (abort) begin
      state_d = IDLE;
      txn_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launchDirect) begin
            state_d = ISSUE;
            cmd_d   = newCmd;
          end
        end
        ISSUE: begin
          if (handshake) state_d = WAIT;
        end
        WAIT: begin
          if (retire) begin
            state_d = IDLE;
            if (launchDirect) begin
              state_d = ISSUE;
              cmd_d   = newCmd;
            end
`ifdef PI_POSTED_WRITE_EN
            if (skidValid_q) begin
              state_d = ISSUE;
              cmd_d   = skid_q;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase

      if (retire && !skidBusy) txn_d = 1'b0;
`ifdef PI_POSTED_WRITE_EN
      if (handshake && !cmd_q.rw) txn_d = 1'b0;
`endif
      if (launchOk) txn_d = 1'b1;
    end
  end

  always_comb begin
    overrun_d = statusRdHit ? 1'b0 : overrun_q;
    if (launchReq && !launchOk) overrun_d = 1'b1;

    berr_d = statusRdHit ? 1'b0 : berr_q;
    if ((rspRetire && rsp_berr_i) || timeoutRetire) berr_d = 1'b1;

    rdata_d = rdata_q;
    if (rspRetire && cmd_q.rw) begin
      rdata_d = rsp_rdata_i;
    end else if (timeoutRetire) begin
      rdata_d = 16'hFFFF;
    end

    cnt_d = cnt_q;
    if (handshake) begin
      cnt_d = '0;
    end else if ((state_q == WAIT) && (cnt_q != TO_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pi_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      txn_q      <= 1'b0;
      run_q      <= 1'b0;
      overrun_q  <= 1'b0;
      berr_q     <= 1'b0;
      addrLo_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      statusRd_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      txn_q     <= txn_d;
      overrun_q <= overrun_d;
      berr_q    <= berr_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      if (wrPulse && (pi_a_i == REG_DATA))    wdata_q  <= pi_d_in_i;
      if (wrPulse && (pi_a_i == REG_ADDR_LO)) addrLo_q <= pi_d_in_i;
      if (wrPulse && (pi_a_i == REG_STATUS))  run_q    <= pi_d_in_i[STAT_RUN];
      if (statusRdHit) statusRd_q <= statusWord(ipl_i, overrun_q, berr_q, !run_q);
    end
  end

  assign pi_d_out_o           = (pi_a_i == REG_STATUS) ? statusRd_q : rdata_q;
  assign pi_d_oe_o            = pi_rd_i && ((pi_a_i == REG_DATA) || (pi_a_i == REG_STATUS));
  assign pi_txn_in_progress_o = txn_q;
  assign cmd_valid_o          = (state_q == ISSUE);
  assign cmd_addr_o           = ADDR_W'(cmd_q.addr);
  assign cmd_rw_o             = cmd_q.rw;
  assign cmd_byte_o           = cmd_q.isByte;
  assign cmd_fc_o             = cmd_q.fc;
  assign cmd_wdata_o          = cmd_q.wdata;
  assign reset_req_o          = !run_q;

endmodule

// File: tb/tb_pi_txn_frontend.sv
// Directed self-checking bench for pi_txn_frontend (timeout shortened to 16 cycles).
`timescale 1ns/1ps
module tb_pi_txn_frontend;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_ADDRLO = 2'd1;
   localparam logic [1:0] A_ADDRHI = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [1:0]  piA = 2'd0;
   logic        piRd = 1'b0;
   logic        piWr = 1'b0;
   logic [15:0] piDIn = '0;
   logic [15:0] piDOut;
   logic        piDOe;
   logic        txn;
   logic [2:0]  ipl = 3'b101;
   logic        cmdValid;
   logic        cmdReady = 1'b0;
   logic [23:0] cmdAddr;
   logic        cmdRw;
   logic        cmdByte;
   logic [2:0]  cmdFc;
   logic [15:0] cmdWdata;
   logic        rspValid = 1'b0;
   logic [15:0] rspRdata = '0;
   logic        rspBerr = 1'b0;
   logic        resetReq;

   int checks = 0;
   int bad = 0;
   logic [15:0] rdVal;
   logic        rdOe;

   pi_txn_frontend #(.ADDR_W(24), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
      .pi_clk_i             (clk),
      .sys_reset_n_i        (rstN),
      .pi_a_i               (piA),
      .pi_rd_i              (piRd),
      .pi_wr_i              (piWr),
      .pi_d_in_i            (piDIn),
      .pi_d_out_o           (piDOut),
      .pi_d_oe_o            (piDOe),
      .pi_txn_in_progress_o (txn),
      .ipl_i                (ipl),
      .cmd_valid_o          (cmdValid),
      .cmd_ready_i          (cmdReady),
      .cmd_addr_o           (cmdAddr),
      .cmd_rw_o             (cmdRw),
      .cmd_byte_o           (cmdByte),
      .cmd_fc_o             (cmdFc),
      .cmd_wdata_o          (cmdWdata),
      .rsp_valid_i          (rspValid),
      .rsp_rdata_i          (rspRdata),
      .rsp_berr_i           (rspBerr),
      .reset_req_o          (resetReq)
   );

   always #5 clk = ~clk;

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise PI_WR and return once the register side effect is visible.
   task automatic wrStart(input logic [1:0] a, input logic [15:0] d);
      piA   = a;
      piDIn = d;
      piWr  = 1'b1;
      cyc(3);
   endtask

   task automatic wrEnd();
      piWr = 1'b0;
      cyc(2);
   endtask

   task automatic regWrite(input logic [1:0] a, input logic [15:0] d);
      wrStart(a, d);
      wrEnd();
   endtask

   task automatic regRead(input logic [1:0] a, output logic [15:0] d, output logic oe);
      piA  = a;
      piRd = 1'b1;
      cyc(3);
      d    = piDOut;
      oe   = piDOe;
      piRd = 1'b0;
      cyc(2);
   endtask

   task automatic pulseRsp(input logic [15:0] data, input logic berr);
      rspValid = 1'b1;
      rspRdata = data;
      rspBerr  = berr;
      cyc(1);
      rspValid = 1'b0;
      rspBerr  = 1'b0;
   endtask

   task automatic test_reset();
      cyc(3);
      rstN = 1'b1;
      cyc(1);
      checks++; if (cmdValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_cmd_valid got=%0h want=0", cmdValid); end
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL reset_txn got=%0h want=0", txn); end
      checks++; if (resetReq !== 1'b1) begin bad++; $display("[TB] FAIL reset_reset_req got=%0h want=1", resetReq); end
      checks++; if (piDOut !== 16'h0000) begin bad++; $display("[TB] FAIL reset_d_out got=%0h want=0", piDOut); end
      checks++; if (piDOe !== 1'b0) begin bad++; $display("[TB] FAIL reset_d_oe got=%0h want=0", piDOe); end
      checks++; if (cmdAddr !== 24'h0) begin bad++; $display("[TB] FAIL reset_cmd_addr got=%0h want=0", cmdAddr); end
   endtask

   task automatic test_read_txn();
      cmdReady = 1'b1;
      regWrite(A_STATUS, 16'h0002);
      checks++; if (resetReq !== 1'b0) begin bad++; $display("[TB] FAIL run_reset_req got=%0h want=0", resetReq); end
      regWrite(A_DATA, 16'h1357);
      regWrite(A_ADDRLO, 16'h5678);
      wrStart(A_ADDRHI, 16'h0312);
      checks++; if (cmdValid !== 1'b1) begin bad++; $display("[TB] FAIL read_cmd_valid got=%0h want=1", cmdValid); end
      checks++; if (cmdAddr !== 24'h125678) begin bad++; $display("[TB] FAIL read_cmd_addr got=%0h want=125678", cmdAddr); end
      checks++; if (cmdByte !== 1'b1) begin bad++; $display("[TB] FAIL read_cmd_byte got=%0h want=1", cmdByte); end
      checks++; if (cmdRw !== 1'b1) begin bad++; $display("[TB] FAIL read_cmd_rw got=%0h want=1", cmdRw); end
      checks++; if (cmdWdata !== 16'h1357) begin bad++; $display("[TB] FAIL read_cmd_wdata got=%0h want=1357", cmdWdata); end
      checks++; if (txn !== 1'b1) begin bad++; $display("[TB] FAIL read_txn_launch got=%0h want=1", txn); end
      wrEnd();
      checks++; if (cmdValid !== 1'b0) begin bad++; $display("[TB] FAIL read_valid_after_hs got=%0h want=0", cmdValid); end
      checks++; if (txn !== 1'b1) begin bad++; $display("[TB] FAIL read_txn_wait got=%0h want=1", txn); end
      pulseRsp(16'hBEEF, 1'b0);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL read_txn_retire got=%0h want=0", txn); end
      regRead(A_DATA, rdVal, rdOe);
      checks++; if (rdVal !== 16'hBEEF) begin bad++; $display("[TB] FAIL read_data got=%0h want=beef", rdVal); end
      checks++; if (rdOe !== 1'b1) begin bad++; $display("[TB] FAIL read_data_oe got=%0h want=1", rdOe); end
      piA  = A_ADDRLO;
      piRd = 1'b1;
      #1;
      checks++; if (piDOe !== 1'b0) begin bad++; $display("[TB] FAIL addr_read_oe got=%0h want=0", piDOe); end
      piRd = 1'b0;
      cyc(3);
   endtask

   task automatic test_overrun();
      wrStart(A_ADDRHI, 16'h0200);
      checks++; if (cmdValid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_first_valid got=%0h want=1", cmdValid); end
      wrEnd();
      wrStart(A_ADDRHI, 16'h0234);
      checks++; if (cmdValid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_second_valid got=%0h want=0", cmdValid); end
      checks++; if (cmdAddr !== 24'h005678) begin bad++; $display("[TB] FAIL ovr_addr_kept got=%0h want=005678", cmdAddr); end
      wrEnd();
      regRead(A_STATUS, rdVal, rdOe);
      checks++; if (rdVal !== 16'hA008) begin bad++; $display("[TB] FAIL ovr_status_set got=%0h want=a008", rdVal); end
      pulseRsp(16'h1234, 1'b0);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL ovr_txn_retire got=%0h want=0", txn); end
      regRead(A_DATA, rdVal, rdOe);
      checks++; if (rdVal !== 16'h1234) begin bad++; $display("[TB] FAIL ovr_data got=%0h want=1234", rdVal); end
      regRead(A_STATUS, rdVal, rdOe);
      checks++; if (rdVal !== 16'hA000) begin bad++; $display("[TB] FAIL ovr_status_clear got=%0h want=a000", rdVal); end
   endtask

   task automatic test_timeout();
      wrStart(A_ADDRHI, 16'h0200);
      wrEnd();
      cyc(14);
      checks++; if (txn !== 1'b1) begin bad++; $display("[TB] FAIL to_txn_before got=%0h want=1", txn); end
      cyc(1);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL to_txn_after got=%0h want=0", txn); end
      regRead(A_STATUS, rdVal, rdOe);
      checks++; if (rdVal !== 16'hA004) begin bad++; $display("[TB] FAIL to_status_berr got=%0h want=a004", rdVal); end
      regRead(A_DATA, rdVal, rdOe);
      checks++; if (rdVal !== 16'hFFFF) begin bad++; $display("[TB] FAIL to_data got=%0h want=ffff", rdVal); end
   endtask

   task automatic test_abort();
      wrStart(A_ADDRHI, 16'h0200);
      wrEnd();
      wrStart(A_STATUS, 16'h0000);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL abort_txn got=%0h want=0", txn); end
      checks++; if (resetReq !== 1'b1) begin bad++; $display("[TB] FAIL abort_reset_req got=%0h want=1", resetReq); end
      checks++; if (cmdValid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid got=%0h want=0", cmdValid); end
      wrEnd();
      pulseRsp(16'h5555, 1'b1);
      cyc(2);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL abort_late_txn got=%0h want=0", txn); end
      regRead(A_DATA, rdVal, rdOe);
      checks++; if (rdVal !== 16'hFFFF) begin bad++; $display("[TB] FAIL abort_late_data got=%0h want=ffff", rdVal); end
      regRead(A_STATUS, rdVal, rdOe);
      checks++; if (rdVal !== 16'hA002) begin bad++; $display("[TB] FAIL abort_status got=%0h want=a002", rdVal); end
      regWrite(A_STATUS, 16'h0002);
   endtask

   task automatic test_back_to_back();
      wrStart(A_ADDRHI, 16'h0200);
      wrEnd();
      piA   = A_ADDRHI;
      piDIn = 16'hC056;
      piWr  = 1'b1;
      cyc(2);
      pulseRsp(16'hCAFE, 1'b0);
      checks++; if (cmdValid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid got=%0h want=1", cmdValid); end
      checks++; if (cmdAddr !== 24'h565678) begin bad++; $display("[TB] FAIL b2b_addr got=%0h want=565678", cmdAddr); end
      checks++; if (cmdRw !== 1'b0) begin bad++; $display("[TB] FAIL b2b_rw got=%0h want=0", cmdRw); end
      checks++; if (cmdFc !== 3'd6) begin bad++; $display("[TB] FAIL b2b_fc got=%0h want=6", cmdFc); end
      checks++; if (txn !== 1'b1) begin bad++; $display("[TB] FAIL b2b_txn got=%0h want=1", txn); end
      wrEnd();
      checks++; if (cmdValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valid_hs got=%0h want=0", cmdValid); end
      pulseRsp(16'h0000, 1'b0);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL b2b_txn_retire got=%0h want=0", txn); end
      regRead(A_DATA, rdVal, rdOe);
      checks++; if (rdVal !== 16'hCAFE) begin bad++; $display("[TB] FAIL b2b_data got=%0h want=cafe", rdVal); end
      regRead(A_STATUS, rdVal, rdOe);
      checks++; if (rdVal !== 16'hA000) begin bad++; $display("[TB] FAIL b2b_status got=%0h want=a000", rdVal); end
   endtask

`ifdef PI_POSTED_WRITE_EN
   task automatic test_posted();
      wrStart(A_ADDRHI, 16'h0012);
      checks++; if (cmdValid !== 1'b1) begin bad++; $display("[TB] FAIL post_valid got=%0h want=1", cmdValid); end
      wrEnd();
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL post_txn_hs got=%0h want=0", txn); end
      wrStart(A_ADDRHI, 16'h0034);
      checks++; if (txn !== 1'b1) begin bad++; $display("[TB] FAIL post_skid_txn got=%0h want=1", txn); end
      checks++; if (cmdValid !== 1'b0) begin bad++; $display("[TB] FAIL post_skid_valid got=%0h want=0", cmdValid); end
      wrEnd();
      wrStart(A_ADDRHI, 16'h0056);
      wrEnd();
      pulseRsp(16'h0000, 1'b0);
      checks++; if (cmdValid !== 1'b1) begin bad++; $display("[TB] FAIL post_skid_issue got=%0h want=1", cmdValid); end
      checks++; if (cmdAddr !== 24'h345678) begin bad++; $display("[TB] FAIL post_skid_addr got=%0h want=345678", cmdAddr); end
      cyc(1);
      checks++; if (txn !== 1'b0) begin bad++; $display("[TB] FAIL post_skid_txn_hs got=%0h want=0", txn); end
      pulseRsp(16'h0000, 1'b0);
      regRead(A_STATUS, rdVal, rdOe);
      checks++; if (rdVal !== 16'hA008) begin bad++; $display("[TB] FAIL post_overrun got=%0h want=a008", rdVal); end
   endtask
`endif

   initial begin
      test_reset();
      test_read_txn();
      test_overrun();
      test_timeout();
      test_abort();
      test_back_to_back();
`ifdef PI_POSTED_WRITE_EN
      test_posted();
`endif
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule
